cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Single-way (direct-mapped) cache controller between the CPU data port and one cache_set instance. It also owns the memory-side bus master.
- Looks up each CPU request in the set. Completes hits. On a miss it writes back a dirty victim, refills one word from memory, fills the set, then replays the lookup.
- Keeps saturating hit/miss performance counters.

Parameters:
CACHE_LINE_SIZE, 4, line size in bytes; only 4 is supported (one word per line).
CACHE_SET_DEPTH, 32, depth of the attached cache_set; power of 2; used only for address field widths.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
cpu_read  input  1  CPU read request; held until accepted
cpu_write  input  1  CPU write request; held until accepted
cpu_address  input  DATA_WIDTH  CPU byte address
cpu_writedata  input  DATA_WIDTH  CPU write data
cpu_byteenable  input  DATA_WIDTH/8  CPU byte enables, forwarded to the set
cpu_readdata  output  DATA_WIDTH  read data; valid when cpu_read=1 and cpu_waitrequest=0
cpu_waitrequest  output  1  stall; request is accepted in the cycle it is 0
set_read  output  1  lookup strobe to cache_set
set_write  output  1  hit-write strobe to cache_set
set_address  output  DATA_WIDTH  lookup address; equals cpu_address
set_writedata  output  DATA_WIDTH  equals cpu_writedata
set_byteenable  output  DATA_WIDTH/8  equals cpu_byteenable
set_readdata  input  DATA_WIDTH  set read data; one-cycle latency
set_hit  input  1  set hit (combinational on set_address)
set_valid  input  1  indexed line is valid
set_dirty  input  1  indexed line is dirty
set_dirty_data  input  DATA_WIDTH  victim data
set_victim_address  input  DATA_WIDTH  victim line address ({tag,index,0}); cache_set exports this
fill  output  1  one-cycle fill strobe
fill_address  output  DATA_WIDTH  line address of the refill
fill_data  output  DATA_WIDTH  refill data
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_address  output  DATA_WIDTH  word-aligned memory address
mem_writedata  output  DATA_WIDTH  writeback data
mem_readdata  input  DATA_WIDTH  memory read data
mem_readdatavalid  input  1  memory read data valid
mem_waitrequest  input  1  memory stall; a command is accepted when it is 0
hit_count  output  32  saturating hit counter
miss_count  output  32  saturating miss counter

Behaviour:
- States: IDLE, LOOKUP, WRITEBACK, REFILL, REFILL_WAIT.
- Reset (rst=0, asynchronous): state goes to IDLE. All strobes (set_write, fill, mem_read, mem_write) are 0; counters are 0; cpu_waitrequest=1 if a request is present.
- Reset asserted mid-transfer aborts it immediately. No fill is issued, and the outstanding memory read response is ignored after reset.
- cpu_waitrequest = request & !(state==LOOKUP & set_hit), where request = cpu_read|cpu_write. It is 0 when idle with no request.
- If cpu_read and cpu_write are both 1, the cycle is treated as a write.
- IDLE: set_read=1. On request, go to LOOKUP. set_readdata becomes valid during LOOKUP.
- LOOKUP with set_hit:
  - Read: cpu_readdata=set_readdata, cpu_waitrequest=0.
  - Write: set_write=1 for exactly this cycle, cpu_waitrequest=0.
  - hit_count increments. Next state is IDLE.
- LOOKUP without set_hit:
  - miss_count increments once per request. It does not increment on the replay lookup.
  - If set_valid & set_dirty, go to WRITEBACK; otherwise go to REFILL.
- WRITEBACK:
  - mem_write=1, mem_address=set_victim_address, mem_writedata=set_dirty_data.
  - The victim data is captured into a register on entry and held stable.
  - Go to REFILL on the first cycle with mem_waitrequest=0.
- REFILL:
  - mem_read=1, mem_address = cpu_address with the low 2 bits zeroed.
  - Go to REFILL_WAIT when mem_waitrequest=0.
- REFILL_WAIT:
  - On mem_readdatavalid: fill=1 for one cycle, fill_address=mem_address, fill_data=mem_readdata. Then go to IDLE.
  - The request is still held, so IDLE re-reads the set after the fill edge and LOOKUP hits (replay).
  - A write miss therefore completes as a write hit on replay (write-allocate).
- Minimum latency:
  - Read hit: 2 cycles (IDLE→LOOKUP).
  - Clean miss: 2 + memory latency + 3 cycles.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- The CPU must not change its request while cpu_waitrequest=1. If it does, behaviour is undefined.

Decomposition:
- core.svh (shared): DATA_WIDTH and DATA_RANGE.
- cache_pkg: state enum cache_ctrl_state_t and the address field width functions, shared with cache_set.
- Sub-module: sat_counter (32-bit, inc/clr, saturating), instantiated twice.

Test Plan:
- Cold read of 0x0000_0040, memory latency 3, returns 0xDEAD_BEEF → one mem_read at 0x40, no mem_write, fill once, cpu_readdata=0xDEAD_BEEF, miss_count=1, hit_count=1.
- Repeat read of 0x40 → completes in 2 cycles with no memory traffic; hit_count=2.
- Write 0x1234_5678 to 0x40, then read 0x0000_00C0 (same index, depth 32) → mem_write to 0x40 with data 0x1234_5678, then mem_read at 0xC0.
- Write miss to clean 0x80 → refill, then set_write pulses for exactly 1 cycle; miss_count increments by 1 only.
- mem_waitrequest held high for 5 cycles during WRITEBACK → mem_write and mem_writedata stay stable, and REFILL is not entered early.
- rst low during REFILL_WAIT, with readdatavalid arriving afterwards → no fill pulse, state is IDLE, counters are 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the cache controller and cache set.
package cache_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        REFILL,
        REFILL_WAIT
    } cache_ctrl_state_t;

    function automatic int offset_width(input int line_size);
        return $clog2(line_size);
    endfunction

    function automatic int index_width(input int set_depth);
        return $clog2(set_depth);
    endfunction

    function automatic int tag_width(input int line_size, input int set_depth);
        return DATA_WIDTH - offset_width(line_size) - index_width(set_depth);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-per-line cache controller: lookup, dirty writeback,
// single-word refill and replay, plus saturating hit/miss counters.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = 4,
    parameter int CACHE_SET_DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_read,
    input  logic                      cpu_write,
    input  logic [DATA_WIDTH-1:0]     cpu_address,
    input  logic [DATA_WIDTH-1:0]     cpu_writedata,
    input  logic [DATA_WIDTH/8-1:0]   cpu_byteenable,
    output logic [DATA_WIDTH-1:0]     cpu_readdata,
    output logic                      cpu_waitrequest,
    output logic                      set_read,
    output logic                      set_write,
    output logic [DATA_WIDTH-1:0]     set_address,
    output logic [DATA_WIDTH-1:0]     set_writedata,
    output logic [DATA_WIDTH/8-1:0]   set_byteenable,
    input  logic [DATA_WIDTH-1:0]     set_readdata,
    input  logic                      set_hit,
    input  logic                      set_valid,
    input  logic                      set_dirty,
    input  logic [DATA_WIDTH-1:0]     set_dirty_data,
    input  logic [DATA_WIDTH-1:0]     set_victim_address,
    output logic                      fill,
    output logic [DATA_WIDTH-1:0]     fill_address,
    output logic [DATA_WIDTH-1:0]     fill_data,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [DATA_WIDTH-1:0]     mem_address,
    output logic [DATA_WIDTH-1:0]     mem_writedata,
    input  logic [DATA_WIDTH-1:0]     mem_readdata,
    input  logic                      mem_readdatavalid,
    input  logic                      mem_waitrequest,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count
);

    localparam int OFFSET_W = offset_width(CACHE_LINE_SIZE);
    localparam int INDEX_W  = index_width(CACHE_SET_DEPTH);
    localparam int TAG_W    = tag_width(CACHE_LINE_SIZE, CACHE_SET_DEPTH);

    cache_ctrl_state_t     state;
    logic                  replay;
    logic [DATA_WIDTH-1:0] wb_address;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [DATA_WIDTH-1:0] line_address;
    logic                  request;
    logic                  lookup_hit;
    logic                  first_miss;

    assign request      = cpu_read | cpu_write;
    assign lookup_hit   = (state == LOOKUP) & set_hit;
    // replay marks the second lookup of a request so a miss is counted once
    assign first_miss   = (state == LOOKUP) & ~set_hit & ~replay;
    assign line_address = {cpu_address[DATA_WIDTH-1 -: TAG_W],
                           cpu_address[OFFSET_W +: INDEX_W],
                           {OFFSET_W{1'b0}}};

    // NOTE: memory strobes and set_read are registered alongside the state so
    // they leave the flop stage glitch-free; every transition updates them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            replay     <= 1'b0;
            set_read   <= 1'b1;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            wb_address <= '0;
            wb_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        state    <= LOOKUP;
                        set_read <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (set_hit) begin
                        state    <= IDLE;
                        set_read <= 1'b1;
                        replay   <= 1'b0;
                    end else begin
                        replay <= 1'b1;
                        if (set_valid & set_dirty) begin
                            state      <= WRITEBACK;
                            mem_write  <= 1'b1;
                            wb_address <= set_victim_address;
                            wb_data    <= set_dirty_data;
                        end else begin
                            state    <= REFILL;
                            mem_read <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_waitrequest) begin
                        state     <= REFILL;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                    end
                end
                REFILL: begin
                    if (!mem_waitrequest) begin
                        state    <= REFILL_WAIT;
                        mem_read <= 1'b0;
                    end
                end
                REFILL_WAIT: begin
                    if (mem_readdatavalid) begin
                        state    <= IDLE;
                        set_read <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    set_read  <= 1'b1;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_waitrequest = request & ~lookup_hit;
    assign cpu_readdata    = set_readdata;
    assign set_write       = lookup_hit & cpu_write;
    assign set_address     = cpu_address;
    assign set_writedata   = cpu_writedata;
    assign set_byteenable  = cpu_byteenable;

    // A response arriving outside REFILL_WAIT (e.g. after a reset abort) is dropped.
    assign fill          = (state == REFILL_WAIT) & mem_readdatavalid;
    assign fill_address  = line_address;
    assign fill_data     = mem_readdata;
    assign mem_address   = mem_write ? wb_address : line_address;
    assign mem_writedata = wb_data;

    sat_counter #(.WIDTH(32)) u_hit_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (lookup_hit),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(32)) u_miss_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (first_miss),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache set and memory around the DUT, with a
// flat-memory / direct-mapped reference model predicting every transaction.
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_address, cpu_writedata, cpu_readdata;
    logic [3:0]  cpu_byteenable;
    logic        cpu_waitrequest;
    logic        set_read, set_write;
    logic [31:0] set_address, set_writedata, set_readdata;
    logic [3:0]  set_byteenable;
    logic        set_hit, set_valid, set_dirty;
    logic [31:0] set_dirty_data, set_victim_address;
    logic        fill;
    logic [31:0] fill_address, fill_data;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_readdatavalid, mem_waitrequest;
    logic [31:0] hit_count, miss_count;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
        .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
        .set_read(set_read), .set_write(set_write), .set_address(set_address),
        .set_writedata(set_writedata), .set_byteenable(set_byteenable),
        .set_readdata(set_readdata), .set_hit(set_hit), .set_valid(set_valid),
        .set_dirty(set_dirty), .set_dirty_data(set_dirty_data),
        .set_victim_address(set_victim_address),
        .fill(fill), .fill_address(fill_address), .fill_data(fill_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- cache set environment (32 one-word lines) ----------------
    logic [24:0] st_tag  [32];
    logic        st_v    [32];
    logic        st_d    [32];
    logic [31:0] st_data [32];
    logic [4:0]  s_idx;

    assign s_idx              = set_address[6:2];
    assign set_hit            = st_v[s_idx] && (st_tag[s_idx] == set_address[31:7]);
    assign set_valid          = st_v[s_idx];
    assign set_dirty          = st_d[s_idx];
    assign set_dirty_data     = st_data[s_idx];
    assign set_victim_address = {st_tag[s_idx], s_idx, 2'b00};

    always @(posedge clk) begin
        if (set_read) set_readdata <= st_data[s_idx];
        if (fill) begin
            st_v[fill_address[6:2]]    <= 1'b1;
            st_d[fill_address[6:2]]    <= 1'b0;
            st_tag[fill_address[6:2]]  <= fill_address[31:7];
            st_data[fill_address[6:2]] <= fill_data;
        end
        if (set_write) begin
            for (int b = 0; b < 4; b++)
                if (set_byteenable[b]) st_data[s_idx][8*b +: 8] <= set_writedata[8*b +: 8];
            st_d[s_idx] <= 1'b1;
        end
    end

    // ---------------- memory environment (256 words, driven on negedge) --------
    logic [31:0] mem_arr [256];
    int          mem_lat, wr_left, rd_left, rd_cnt;
    logic [7:0]  rd_word;
    int          wb_n, rd_n;
    logic [31:0] wb_addr_last, wb_data_last, rd_addr_last;

    always @(negedge clk) begin
        mem_readdatavalid <= 1'b0;
        mem_waitrequest   <= 1'b0;
        if (rd_cnt != 0) begin
            if (rd_cnt == 1) begin
                mem_readdatavalid <= 1'b1;
                mem_readdata      <= mem_arr[rd_word];
            end
            rd_cnt <= rd_cnt - 1;
        end
        if (mem_write) begin
            if (wr_left != 0) begin
                mem_waitrequest <= 1'b1;
                wr_left         <= wr_left - 1;
            end else begin
                mem_arr[mem_address[9:2]] <= mem_writedata;
                wb_n         <= wb_n + 1;
                wb_addr_last <= mem_address;
                wb_data_last <= mem_writedata;
            end
        end else if (mem_read) begin
            if (rd_left != 0) begin
                mem_waitrequest <= 1'b1;
                rd_left         <= rd_left - 1;
            end else begin
                rd_cnt       <= mem_lat;
                rd_word      <= mem_address[9:2];
                rd_n         <= rd_n + 1;
                rd_addr_last <= mem_address;
            end
        end
    end

    // ---------------- strobe monitor (mid low phase) ---------------------------
    int          fill_n, sw_n, wbc_n, unst_n;
    logic        prev_mw;
    logic [31:0] prev_ma, prev_md;

    always begin
        @(negedge clk);
        #1;
        if (fill) fill_n <= fill_n + 1;
        if (set_write) sw_n <= sw_n + 1;
        if (mem_write) begin
            wbc_n <= wbc_n + 1;
            if (prev_mw && (mem_address != prev_ma || mem_writedata != prev_md))
                unst_n <= unst_n + 1;
        end
        prev_mw <= mem_write;
        prev_ma <= mem_address;
        prev_md <= mem_writedata;
    end

    // ---------------- reference model and checking -----------------------------
    logic [31:0] ref_mem   [256];
    logic [24:0] ref_tag   [32];
    bit          ref_valid [32];
    bit          ref_dirty [32];
    int          exp_hit, exp_miss;
    int          n_total, n_pass;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    endtask

    // One CPU transaction, started at a negedge; returns at the negedge after acceptance.
    task automatic do_op(input string name, input bit wr, input bit both,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int lat, input int ws, input int rs);
        int          idx, word, cycles, exp_cycles;
        int          wb0, rd0, fill0, sw0, wbc0, unst0;
        bit          hit, evict, done;
        logic [31:0] vaddr, vdata, exp_rd, rdata;

        idx        = int'(addr[6:2]);
        word       = int'(addr[9:2]);
        hit        = ref_valid[idx] && (ref_tag[idx] == addr[31:7]);
        evict      = !hit && ref_valid[idx] && ref_dirty[idx];
        vaddr      = {ref_tag[idx], addr[6:2], 2'b00};
        vdata      = ref_mem[vaddr[9:2]];
        exp_cycles = hit ? 2 : 5 + lat + rs + (evict ? 1 + ws : 0);
        if (!hit) begin
            exp_miss++;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = addr[31:7];
            ref_dirty[idx] = 1'b0;
        end
        exp_hit++;
        exp_rd = ref_mem[word];
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[word][8*b +: 8] = wdata[8*b +: 8];
            ref_dirty[idx] = 1'b1;
        end

        wb0 = wb_n; rd0 = rd_n; fill0 = fill_n; sw0 = sw_n; wbc0 = wbc_n; unst0 = unst_n;
        mem_lat = lat; wr_left = ws; rd_left = rs;
        cpu_address    = addr;
        cpu_writedata  = wdata;
        cpu_byteenable = be;
        cpu_write      = wr;
        cpu_read       = !wr || both;
        cycles = 0; done = 1'b0; rdata = '0;
        while (!done && cycles < 300) begin
            #1;
            cycles++;
            if (!cpu_waitrequest) begin
                done  = 1'b1;
                rdata = cpu_readdata;
            end
            @(negedge clk);
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;

        check({name, " accepted"}, 32'(done), 1);
        check({name, " cycles"}, cycles, exp_cycles);
        if (!wr) check({name, " rdata"}, rdata, exp_rd);
        check({name, " hit_count"}, hit_count, exp_hit);
        check({name, " miss_count"}, miss_count, exp_miss);
        check({name, " mem_writes"}, wb_n - wb0, 32'(evict));
        if (evict) begin
            check({name, " wb addr"}, wb_addr_last, vaddr);
            check({name, " wb data"}, wb_data_last, vdata);
        end
        check({name, " wb cycles"}, wbc_n - wbc0, evict ? 1 + ws : 0);
        check({name, " wb stable"}, unst_n - unst0, 0);
        check({name, " mem_reads"}, rd_n - rd0, 32'(!hit));
        if (!hit) check({name, " rd addr"}, rd_addr_last, {addr[31:2], 2'b00});
        check({name, " fills"}, fill_n - fill0, 32'(!hit));
        check({name, " set_write cycles"}, sw_n - sw0, 32'(wr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n, fill0, rd0;
        bit          wr, both;
        logic [31:0] a;

        n_total = 0; n_pass = 0; exp_hit = 0; exp_miss = 0;
        wb_n = 0; rd_n = 0; fill_n = 0; sw_n = 0; wbc_n = 0; unst_n = 0;
        rd_cnt = 0; wr_left = 0; rd_left = 0; mem_lat = 3; prev_mw = 1'b0;
        mem_readdata = '0; mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0;
        for (int i = 0; i < 32; i++) begin
            st_v[i] = 1'b0; st_d[i] = 1'b0; st_tag[i] = '0; st_data[i] = '0;
            ref_valid[i] = 1'b0; ref_dirty[i] = 1'b0; ref_tag[i] = '0;
        end
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[8'h10] = 32'hDEAD_BEEF;
        ref_mem[8'h10] = 32'hDEAD_BEEF;

        rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_address = '0; cpu_writedata = '0; cpu_byteenable = 4'hF;
        #3;
        rst = 1'b0;
        cpu_read = 1'b1; cpu_address = 32'h40;
        #1;
        check("reset waitrequest with request", cpu_waitrequest, 1);
        check("reset hit_count", hit_count, 0);
        check("reset miss_count", miss_count, 0);
        check("reset mem_read", mem_read, 0);
        check("reset mem_write", mem_write, 0);
        check("reset fill", fill, 0);
        check("reset set_write", set_write, 0);
        cpu_read = 1'b0;
        #1;
        check("reset waitrequest idle", cpu_waitrequest, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_op("cold_rd_40", 1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 3, 0, 0);
        do_op("hit_rd_40", 1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 3, 0, 0);
        do_op("hit_wr_40", 1'b1, 1'b0, 32'h40, 32'h1234_5678, 4'hF, 3, 0, 0);
        do_op("evict_rd_c0", 1'b0, 1'b0, 32'hC0, 32'h0, 4'hF, 2, 0, 0);
        do_op("wr_miss_80", 1'b1, 1'b0, 32'h80, 32'hA5A5_0F0F, 4'hF, 2, 0, 0);
        do_op("wb_stall_rd_100", 1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 2, 5, 0);

        // Abort a refill with reset while the read response is still in flight.
        mem_lat = 6; wr_left = 0; rd_left = 0;
        fill0 = fill_n; rd0 = rd_n;
        cpu_address = 32'h200; cpu_read = 1'b1;
        n = 0;
        while (rd_n == rd0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort refill issued", rd_n - rd0, 1);
        @(negedge clk);
        rst = 1'b0;
        cpu_read = 1'b0;
        #1;
        check("abort fill", fill, 0);
        check("abort mem_read", mem_read, 0);
        check("abort hit_count", hit_count, 0);
        check("abort miss_count", miss_count, 0);
        check("abort waitrequest idle", cpu_waitrequest, 0);
        repeat (8) @(negedge clk);
        check("abort late response ignored", fill_n - fill0, 0);
        rst = 1'b1;
        #1;
        check("abort back in idle", set_read, 1);
        @(negedge clk);
        exp_hit = 0; exp_miss = 0;
        do_op("after_abort_rd_200", 1'b0, 1'b0, 32'h200, 32'h0, 4'hF, 2, 0, 0);

        // Randomized traffic over a few indices and tags to force conflicts.
        for (int i = 0; i < 60; i++) begin
            a    = ($urandom_range(0, 7) << 7) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            wr   = ($urandom_range(0, 1) == 1);
            both = wr && ($urandom_range(0, 3) == 0);
            do_op("rnd", wr, both, a, $urandom, 4'($urandom_range(1, 15)),
                  $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
